irq_ctrl: RTL and testbench

- Interrupt controller for the 16-bit pipelined processor.
- Captures edge events from up to NDEV device request lines (keys, switches, timer) and latches them as pending.
- Arbitrates pending, unmasked requests by fixed priority and presents one request to the pipeline control logic, holding it until the pipeline flushes and takes it.
- Tracks the in-service state until RETI; supplies the interrupt ID used to load SII.

---
 rtl/irq_ctrl.sv | 134 +++++++++++++
 tb/tb_irq_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronizes device request edges, latches them as pending,
// and presents one fixed-priority request to the pipeline until TAKE, then tracks service until RETI.
module irq_ctrl #(
  parameter int NDEV   = 4,
  parameter int IDBITS = 3,
  parameter int DBITS  = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NDEV-1:0]   DEVREQ,
  input  logic [NDEV-1:0]   MASK,
  input  logic              IE,
  input  logic              TAKE,
  input  logic              RETI,
  output logic              IRQ,
  output logic [IDBITS-1:0] IID,
  output logic [DBITS-1:0]  SIIVAL,
  output logic [NDEV-1:0]   DEVACK,
  output logic [NDEV-1:0]   PEND,
  output logic              INSVC
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } state_t;

  state_t state, state_n;

  logic [NDEV-1:0]   sync1, sync2, hist;
  logic [NDEV-1:0]   rise;
  logic [NDEV-1:0]   eligible;
  logic [NDEV-1:0]   iid_oh;
  logic [NDEV-1:0]   pend_n;
  logic [NDEV-1:0]   devack_n;
  logic [IDBITS-1:0] winner;
  logic [IDBITS-1:0] iid_n;
  logic              irq_n;
  logic              insvc_n;
  logic              iid_enabled;

  // Two-flop synchronizer plus a history flop; only a fresh 0->1 transition counts.
  assign rise     = sync2 & ~hist;
  assign eligible = PEND & MASK;

  // Descending scan so the lowest eligible index is the last (winning) assignment.
  always_comb begin
    winner = '0;
    for (int i = NDEV - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winner = IDBITS'(i);
      end
    end
  end

  always_comb begin
    iid_oh = '0;
    for (int i = 0; i < NDEV; i++) begin
      iid_oh[i] = (IID == IDBITS'(i));
    end
  end

  assign iid_enabled = |(MASK & iid_oh);

  always_comb begin
    state_n  = state;
    irq_n    = IRQ;
    iid_n    = IID;
    insvc_n  = INSVC;
    devack_n = '0;
    case (state)
      IDLE: begin
        if (IE && (|eligible)) begin
          state_n = REQ;
          irq_n   = 1'b1;
          iid_n   = winner;
        end
      end
      REQ: begin
        // TAKE wins over a same-cycle enable drop: the pipeline has already redirected.
        if (TAKE) begin
          state_n  = SVC;
          irq_n    = 1'b0;
          insvc_n  = 1'b1;
          devack_n = iid_oh;
        end else if (!IE || !iid_enabled) begin
          state_n = IDLE;
          irq_n   = 1'b0;
        end
      end
      SVC: begin
        if (RETI) begin
          state_n = IDLE;
          insvc_n = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
        irq_n   = 1'b0;
        insvc_n = 1'b0;
      end
    endcase
    // A new edge arriving with the service clear is kept pending.
    pend_n = (PEND & ~devack_n) | rise;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= IDLE;
      sync1  <= '0;
      sync2  <= '0;
      hist   <= '0;
      PEND   <= '0;
      IRQ    <= 1'b0;
      IID    <= '0;
      DEVACK <= '0;
      INSVC  <= 1'b0;
    end else begin
      state  <= state_n;
      sync1  <= DEVREQ;
      sync2  <= sync1;
      hist   <= sync2;
      PEND   <= pend_n;
      IRQ    <= irq_n;
      IID    <= iid_n;
      DEVACK <= devack_n;
      INSVC  <= insvc_n;
    end
  end

  assign SIIVAL = DBITS'(IID);

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios plus a randomized run against a
// transaction-level reference model of the controller.
module tb_irq_ctrl;
  localparam int NDEV   = 4;
  localparam int IDBITS = 3;
  localparam int DBITS  = 16;
  localparam int P_IDLE = 0;
  localparam int P_REQ  = 1;
  localparam int P_SVC  = 2;

  logic              CLK = 1'b0;
  logic              RESET, IE, TAKE, RETI;
  logic [NDEV-1:0]   DEVREQ, MASK;
  logic              IRQ, INSVC;
  logic [IDBITS-1:0] IID;
  logic [DBITS-1:0]  SIIVAL;
  logic [NDEV-1:0]   DEVACK, PEND;

  int n_cmp = 0;
  int n_bad = 0;

  irq_ctrl #(.NDEV(NDEV), .IDBITS(IDBITS), .DBITS(DBITS)) dut (
    .CLK(CLK), .RESET(RESET), .DEVREQ(DEVREQ), .MASK(MASK), .IE(IE),
    .TAKE(TAKE), .RETI(RETI), .IRQ(IRQ), .IID(IID), .SIIVAL(SIIVAL),
    .DEVACK(DEVACK), .PEND(PEND), .INSVC(INSVC)
  );

  always #5 CLK = ~CLK;

  // Reference model: a request line counts as a new event when the value sampled two
  // clocks ago is 1 and the one before that is 0; the phase tracks request/service.
  logic [NDEV-1:0]   m_pend, m_devack, d1, d2, d3;
  logic              m_irq, m_insvc;
  logic [IDBITS-1:0] m_iid;
  int                m_phase;

  always @(posedge CLK) begin
    logic [NDEV-1:0] events, elig;
    int w;
    if (RESET) begin
      m_pend = '0; m_devack = '0; d1 = '0; d2 = '0; d3 = '0;
      m_irq = 1'b0; m_insvc = 1'b0; m_iid = '0; m_phase = P_IDLE;
    end else begin
      events   = d2 & ~d3;
      elig     = m_pend & MASK;
      m_devack = '0;
      if (m_phase == P_IDLE) begin
        if (IE && elig != 0) begin
          w = 0;
          while (((elig >> w) & 1) == 0) w++;
          m_phase = P_REQ; m_irq = 1'b1; m_iid = IDBITS'(w);
        end
      end else if (m_phase == P_REQ) begin
        if (TAKE) begin
          m_phase = P_SVC; m_irq = 1'b0; m_insvc = 1'b1;
          m_devack = NDEV'(1) << m_iid;
        end else if (!IE || ((MASK >> m_iid) & 1) == 0) begin
          m_phase = P_IDLE; m_irq = 1'b0;
        end
      end else if (RETI) begin
        m_phase = P_IDLE; m_insvc = 1'b0;
      end
      m_pend = (m_pend & ~m_devack) | events;
      d3 = d2; d2 = d1; d1 = DEVREQ;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic pulse_take();
    TAKE = 1'b1; tick(1); TAKE = 1'b0;
  endtask

  task automatic pulse_reti();
    RETI = 1'b1; tick(1); RETI = 1'b0;
  endtask

  task automatic wait_irq(input string name);
    for (int i = 0; i < 12 && IRQ !== 1'b1; i++) tick(1);
    n_cmp++; if (IRQ !== 1'b1) begin n_bad++; $display("FAIL %s_irq_timeout got %0b want 1", name, IRQ); end
  endtask

  task automatic test_reset();
    RESET = 1'b1; tick(2);
    n_cmp++; if (IRQ !== 1'b0)      begin n_bad++; $display("FAIL reset_irq got %0h want 0", IRQ); end
    n_cmp++; if (IID !== '0)        begin n_bad++; $display("FAIL reset_iid got %0h want 0", IID); end
    n_cmp++; if (SIIVAL !== '0)     begin n_bad++; $display("FAIL reset_siival got %0h want 0", SIIVAL); end
    n_cmp++; if (DEVACK !== '0)     begin n_bad++; $display("FAIL reset_devack got %0h want 0", DEVACK); end
    n_cmp++; if (PEND !== '0)       begin n_bad++; $display("FAIL reset_pend got %0h want 0", PEND); end
    n_cmp++; if (INSVC !== 1'b0)    begin n_bad++; $display("FAIL reset_insvc got %0h want 0", INSVC); end
    RESET = 1'b0; tick(1);
  endtask

  task automatic test_basic();
    DEVREQ = 4'b0001; tick(2);
    n_cmp++; if (PEND !== 4'b0000)  begin n_bad++; $display("FAIL basic_pend_early got %0h want 0", PEND); end
    tick(1);
    n_cmp++; if (PEND !== 4'b0001)  begin n_bad++; $display("FAIL basic_pend got %0h want 1", PEND); end
    n_cmp++; if (IRQ !== 1'b0)      begin n_bad++; $display("FAIL basic_irq_early got %0h want 0", IRQ); end
    tick(1);
    n_cmp++; if (IRQ !== 1'b1)      begin n_bad++; $display("FAIL basic_irq got %0h want 1", IRQ); end
    n_cmp++; if (IID !== 3'd0)      begin n_bad++; $display("FAIL basic_iid got %0h want 0", IID); end
    n_cmp++; if (SIIVAL !== 16'h0)  begin n_bad++; $display("FAIL basic_siival got %0h want 0", SIIVAL); end
    pulse_take();
    n_cmp++; if (DEVACK !== 4'b0001) begin n_bad++; $display("FAIL basic_devack got %0h want 1", DEVACK); end
    n_cmp++; if (INSVC !== 1'b1)    begin n_bad++; $display("FAIL basic_insvc got %0h want 1", INSVC); end
    n_cmp++; if (PEND !== 4'b0000)  begin n_bad++; $display("FAIL basic_pend_clr got %0h want 0", PEND); end
    n_cmp++; if (IRQ !== 1'b0)      begin n_bad++; $display("FAIL basic_irq_clr got %0h want 0", IRQ); end
    tick(1);
    n_cmp++; if (DEVACK !== 4'b0000) begin n_bad++; $display("FAIL basic_devack_1cyc got %0h want 0", DEVACK); end
    pulse_reti();
    n_cmp++; if (INSVC !== 1'b0)    begin n_bad++; $display("FAIL basic_insvc_reti got %0h want 0", INSVC); end
    DEVREQ = '0; tick(3);
  endtask

  task automatic test_priority();
    DEVREQ = 4'b0110; wait_irq("prio");
    n_cmp++; if (IID !== 3'd1)      begin n_bad++; $display("FAIL prio_iid got %0h want 1", IID); end
    pulse_take();
    n_cmp++; if (DEVACK !== 4'b0010) begin n_bad++; $display("FAIL prio_devack got %0h want 2", DEVACK); end
    n_cmp++; if (PEND !== 4'b0100)  begin n_bad++; $display("FAIL prio_pend got %0h want 4", PEND); end
    n_cmp++; if (INSVC !== 1'b1)    begin n_bad++; $display("FAIL prio_insvc got %0h want 1", INSVC); end
    tick(2);
    n_cmp++; if (IRQ !== 1'b0)      begin n_bad++; $display("FAIL prio_no_nest got %0h want 0", IRQ); end
    pulse_reti();
    n_cmp++; if (IRQ !== 1'b0)      begin n_bad++; $display("FAIL prio_reti_lat1 got %0h want 0", IRQ); end
    tick(1);
    n_cmp++; if (IRQ !== 1'b1)      begin n_bad++; $display("FAIL prio_reti_lat2 got %0h want 1", IRQ); end
    n_cmp++; if (IID !== 3'd2)      begin n_bad++; $display("FAIL prio_iid2 got %0h want 2", IID); end
    n_cmp++; if (SIIVAL !== 16'h2)  begin n_bad++; $display("FAIL prio_siival2 got %0h want 2", SIIVAL); end
    pulse_take(); pulse_reti();
    DEVREQ = '0; tick(3);
  endtask

  task automatic test_frozen();
    DEVREQ = 4'b1000; wait_irq("frozen");
    n_cmp++; if (IID !== 3'd3)      begin n_bad++; $display("FAIL frozen_iid got %0h want 3", IID); end
    DEVREQ = 4'b1001; tick(5);
    n_cmp++; if (IID !== 3'd3)      begin n_bad++; $display("FAIL frozen_iid_hold got %0h want 3", IID); end
    n_cmp++; if (SIIVAL !== 16'h3)  begin n_bad++; $display("FAIL frozen_siival got %0h want 3", SIIVAL); end
    n_cmp++; if (PEND !== 4'b1001)  begin n_bad++; $display("FAIL frozen_pend got %0h want 9", PEND); end
    pulse_take();
    n_cmp++; if (DEVACK !== 4'b1000) begin n_bad++; $display("FAIL frozen_devack got %0h want 8", DEVACK); end
    pulse_reti(); tick(1);
    n_cmp++; if (IRQ !== 1'b1)      begin n_bad++; $display("FAIL frozen_next_irq got %0h want 1", IRQ); end
    n_cmp++; if (IID !== 3'd0)      begin n_bad++; $display("FAIL frozen_next_iid got %0h want 0", IID); end
    pulse_take(); pulse_reti();
    DEVREQ = '0; tick(3);
  endtask

  task automatic test_mask_enable();
    MASK = 4'b0111; DEVREQ = 4'b1000; tick(6);
    n_cmp++; if (IRQ !== 1'b0)      begin n_bad++; $display("FAIL mask_irq_off got %0h want 0", IRQ); end
    n_cmp++; if (PEND !== 4'b1000)  begin n_bad++; $display("FAIL mask_pend got %0h want 8", PEND); end
    MASK = 4'b1111; tick(1);
    n_cmp++; if (IRQ !== 1'b1)      begin n_bad++; $display("FAIL mask_irq_on got %0h want 1", IRQ); end
    IE = 1'b0; tick(1);
    n_cmp++; if (IRQ !== 1'b0)      begin n_bad++; $display("FAIL ie_drop_irq got %0h want 0", IRQ); end
    n_cmp++; if (PEND !== 4'b1000)  begin n_bad++; $display("FAIL ie_drop_pend got %0h want 8", PEND); end
    IE = 1'b1; tick(1);
    n_cmp++; if (IRQ !== 1'b1)      begin n_bad++; $display("FAIL ie_back_irq got %0h want 1", IRQ); end
    MASK = 4'b0111; tick(1);
    n_cmp++; if (IRQ !== 1'b0)      begin n_bad++; $display("FAIL mask_drop_irq got %0h want 0", IRQ); end
    MASK = 4'b1111; tick(1);
    pulse_take(); pulse_reti();
    DEVREQ = '0; tick(3);
  endtask

  task automatic test_edge_collision();
    int pend_rises = 0;
    int acks = 0;
    logic prev = 1'b0;
    DEVREQ = 4'b0100;
    for (int i = 0; i < 50; i++) begin
      TAKE = IRQ; RETI = INSVC; tick(1);
      if (PEND[2] && !prev) pend_rises++;
      prev = PEND[2];
      if (DEVACK[2]) acks++;
    end
    TAKE = 1'b0; RETI = 1'b0;
    n_cmp++; if (pend_rises !== 1)  begin n_bad++; $display("FAIL hold_pend_sets got %0d want 1", pend_rises); end
    n_cmp++; if (acks !== 1)        begin n_bad++; $display("FAIL hold_devacks got %0d want 1", acks); end
    DEVREQ = '0; tick(4);
    DEVREQ = 4'b0100; wait_irq("collide");
    DEVREQ = '0; tick(3);
    DEVREQ = 4'b0100; tick(2);
    pulse_take();
    n_cmp++; if (DEVACK !== 4'b0100) begin n_bad++; $display("FAIL collide_devack got %0h want 4", DEVACK); end
    n_cmp++; if (PEND[2] !== 1'b1)  begin n_bad++; $display("FAIL collide_pend got %0h want 1", PEND[2]); end
    pulse_reti(); tick(1);
    n_cmp++; if (IRQ !== 1'b1)      begin n_bad++; $display("FAIL collide_reirq got %0h want 1", IRQ); end
    pulse_take(); pulse_reti();
    DEVREQ = '0; tick(3);
  endtask

  task automatic test_reset_svc();
    DEVREQ = 4'b0111; wait_irq("rstsvc");
    n_cmp++; if (IID !== 3'd0)      begin n_bad++; $display("FAIL rstsvc_iid got %0h want 0", IID); end
    pulse_take();
    n_cmp++; if (PEND !== 4'b0110)  begin n_bad++; $display("FAIL rstsvc_pend got %0h want 6", PEND); end
    DEVREQ = '0; tick(1);
    RESET = 1'b1; tick(1); RESET = 1'b0;
    n_cmp++; if ({IRQ, INSVC} !== 2'b00) begin n_bad++; $display("FAIL rstsvc_irq_insvc got %0h want 0", {IRQ, INSVC}); end
    n_cmp++; if (PEND !== '0)       begin n_bad++; $display("FAIL rstsvc_pend_clr got %0h want 0", PEND); end
    n_cmp++; if (DEVACK !== '0)     begin n_bad++; $display("FAIL rstsvc_devack got %0h want 0", DEVACK); end
    n_cmp++; if (SIIVAL !== '0)     begin n_bad++; $display("FAIL rstsvc_siival got %0h want 0", SIIVAL); end
    pulse_take();
    n_cmp++; if (DEVACK !== '0)     begin n_bad++; $display("FAIL rstsvc_take_ignored got %0h want 0", DEVACK); end
    n_cmp++; if (INSVC !== 1'b0)    begin n_bad++; $display("FAIL rstsvc_take_insvc got %0h want 0", INSVC); end
    tick(4);
    n_cmp++; if ({IRQ, PEND} !== '0) begin n_bad++; $display("FAIL rstsvc_quiet got %0h want 0", {IRQ, PEND}); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < NDEV; b++) if ($urandom_range(7) == 0) DEVREQ[b] = ~DEVREQ[b];
      if ($urandom_range(31) == 0) MASK = NDEV'($urandom);
      IE    = ($urandom_range(9) != 0);
      TAKE  = $urandom_range(1) == 1;
      RETI  = ($urandom_range(4) == 0);
      RESET = ($urandom_range(199) == 0);
      tick(1);
      n_cmp++; if (IRQ !== m_irq)       begin n_bad++; $display("FAIL rnd_irq c=%0d got %0h want %0h", c, IRQ, m_irq); end
      n_cmp++; if (IID !== m_iid)       begin n_bad++; $display("FAIL rnd_iid c=%0d got %0h want %0h", c, IID, m_iid); end
      n_cmp++; if (SIIVAL !== DBITS'(m_iid)) begin n_bad++; $display("FAIL rnd_siival c=%0d got %0h want %0h", c, SIIVAL, m_iid); end
      n_cmp++; if (DEVACK !== m_devack) begin n_bad++; $display("FAIL rnd_devack c=%0d got %0h want %0h", c, DEVACK, m_devack); end
      n_cmp++; if (PEND !== m_pend)     begin n_bad++; $display("FAIL rnd_pend c=%0d got %0h want %0h", c, PEND, m_pend); end
      n_cmp++; if (INSVC !== m_insvc)   begin n_bad++; $display("FAIL rnd_insvc c=%0d got %0h want %0h", c, INSVC, m_insvc); end
    end
    RESET = 1'b0; TAKE = 1'b0; RETI = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; DEVREQ = '0; MASK = '1; IE = 1'b1; TAKE = 1'b0; RETI = 1'b0;
    test_reset();
    test_basic();
    test_priority();
    test_frozen();
    test_mask_enable();
    test_edge_collision();
    test_reset_svc();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
